// File: rtl/mux_pkg.sv
// Shared constants and index helpers for the arbitrated N-to-1 mux.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // (base + off) mod n, valid for base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'(wrap_add(int'(ptr), k, N));
            if (!found && req[cand]) begin
                found       = 1'b1;
                gnt[cand]   = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel valid/ready mux with a single output register, fixed-select or round-robin grant.
module arb_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic [$clog2(N)-1:0] sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_ch,
    input  logic                 out_ready
);

    localparam int IW = $clog2(N);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IW-1:0]    out_ch_q,    out_ch_d;
    logic [IW-1:0]    ptr_q,       ptr_d;

    logic             load_en;
    logic [N-1:0]     rr_gnt;
    logic [IW-1:0]    rr_idx;
    logic [N-1:0]     fix_gnt;
    logic [N-1:0]     gnt;
    logic [IW-1:0]    gnt_idx;
    logic             grant;
    logic [WIDTH-1:0] mux_data;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // A select value with no matching channel (including sel >= N) yields no grant.
    always_comb begin
        fix_gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i) && in_valid[i]) begin
                fix_gnt[i] = 1'b1;
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;

    // out_ready only reaches the grant through load_en; reset masks in_ready immediately.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (load_en && rst_n) begin
            if (MODE == MODE_FIXED) begin
                gnt     = fix_gnt;
                gnt_idx = sel;
            end else begin
                gnt     = rr_gnt;
                gnt_idx = rr_idx;
            end
        end
    end

    assign grant    = |gnt;
    assign in_ready = gnt;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | ({WIDTH{gnt[i]}} & in_data[i*WIDTH +: WIDTH]);
        end
    end

    // A drain and a reload on the same edge collapse into the grant branch: no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_ch_d    = gnt_idx;
            if (MODE == MODE_RR) begin
                ptr_d = IW'(wrap_add(int'(gnt_idx), 1, N));
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops sample together.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_ch_q)));

endmodule

// File: tb/tb_arb_mux_n.sv
// Randomised and directed bench for arb_mux_n: one round-robin and one fixed-select instance.
module tb_arb_mux_n;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [IW-1:0]  sel;
    logic           out_ready;

    logic [N-1:0]   rdy_rr, rdy_fx;
    logic           ov_rr, ov_fx;
    logic [W-1:0]   od_rr, od_fx;
    logic [IW-1:0]  oc_rr, oc_fx;

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_rr),
        .sel(sel), .out_valid(ov_rr), .out_data(od_rr), .out_ch(oc_rr), .out_ready(out_ready)
    );

    arb_mux_n #(.WIDTH(W), .N(N), .MODE(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_fx),
        .sel(sel), .out_valid(ov_fx), .out_data(od_fx), .out_ch(oc_fx), .out_ready(out_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: index 0 = fixed-select instance, 1 = round-robin instance.
    bit         m_v [2];
    logic [W-1:0] m_d [2];
    int         m_c [2];
    int         m_p [2];
    int         exp_g [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_v[m] = 1'b0;
            m_d[m] = '0;
            m_c[m] = 0;
            m_p[m] = 0;
            exp_g[m] = -1;
        end
    endfunction

    function automatic int model_grant(input int m);
        int c;
        if (!rst_n) return -1;
        if (m_v[m] && !out_ready) return -1;
        if (m == 0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            c = (m_p[m] + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic settle();
        logic [N-1:0] er_fx, er_rr;
        #1;
        for (int m = 0; m < 2; m++) exp_g[m] = model_grant(m);
        er_fx = (exp_g[0] >= 0) ? (N'(1) << exp_g[0]) : '0;
        er_rr = (exp_g[1] >= 0) ? (N'(1) << exp_g[1]) : '0;
        check("fx_in_ready", rdy_fx, er_fx);
        check("rr_in_ready", rdy_rr, er_rr);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                if (exp_g[m] >= 0) begin
                    m_v[m] = 1'b1;
                    m_d[m] = in_data[exp_g[m]*W +: W];
                    m_c[m] = exp_g[m];
                    if (m == 1) m_p[m] = (exp_g[m] + 1) % N;
                end else if (out_ready) begin
                    m_v[m] = 1'b0;
                end
            end
        end
        check("fx_out_valid", ov_fx, m_v[0]);
        check("fx_out_data",  od_fx, m_d[0]);
        check("fx_out_ch",    oc_fx, m_c[0]);
        check("rr_out_valid", ov_rr, m_v[1]);
        check("rr_out_data",  od_rr, m_d[1]);
        check("rr_out_ch",    oc_rr, m_c[1]);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        in_valid  = '1;
        sel       = '0;
        out_ready = 1'b1;
        rand_data();
        model_reset();

        // Reset: outputs cleared and in_ready masked regardless of requests.
        @(negedge clk);
        settle();
        check("rst_rr_ready", rdy_rr, 4'b0000);
        check("rst_out_valid", ov_rr, 1'b0);
        check("rst_out_data",  od_rr, 32'h0);
        check("rst_out_ch",    oc_rr, 2'd0);
        clk_edge();
        rst_n = 1'b1;

        // Full throughput rotation with everyone requesting.
        for (int i = 0; i < 5; i++) begin
            rand_data();
            settle();
            clk_edge();
            check("rot_out_ch", oc_rr, seq[i]);
            check("rot_out_valid", ov_rr, 1'b1);
        end

        // Wrap from ch3 to ch0, pointer then sits at 1.
        in_valid = 4'b0100;
        settle();
        clk_edge();
        check("wrap_ch2", oc_rr, 2'd2);
        in_valid = 4'b1000;
        settle();
        check("wrap_rdy3", rdy_rr, 4'b1000);
        clk_edge();
        check("wrap_ch3", oc_rr, 2'd3);
        in_valid = 4'b0001;
        settle();
        check("wrap_rdy0", rdy_rr, 4'b0001);
        clk_edge();
        check("wrap_ch0", oc_rr, 2'd0);
        in_valid = 4'b1111;
        settle();
        check("wrap_ptr1", rdy_rr, 4'b0010);
        clk_edge();

        // Back-pressure: held word stays put and nothing is accepted.
        in_data[2*W +: W] = 32'hA5A5A5A5;
        settle();
        clk_edge();
        check("hold_load", od_rr, 32'hA5A5A5A5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            settle();
            check("hold_rdy", rdy_rr, 4'b0000);
            clk_edge();
            check("hold_data", od_rr, 32'hA5A5A5A5);
            check("hold_valid", ov_rr, 1'b1);
        end

        // Fixed select.
        out_ready = 1'b1;
        sel       = 2'd2;
        in_valid  = 4'b0101;
        in_data[2*W +: W] = 32'h22;
        settle();
        check("fix_rdy", rdy_fx, 4'b0100);
        clk_edge();
        check("fix_data", od_fx, 32'h22);
        check("fix_ch", oc_fx, 2'd2);
        sel = 2'd1;
        settle();
        check("fix_nogrant", rdy_fx, 4'b0000);
        clk_edge();
        check("fix_drain", ov_fx, 1'b0);

        // Asynchronous reset between edges while a word is held.
        in_valid = 4'b1111;
        rand_data();
        settle();
        clk_edge();
        check("arst_pre_valid", ov_rr, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", ov_rr, 1'b0);
        check("arst_ch",    oc_rr, 2'd0);
        check("arst_data",  od_rr, 32'h0);
        check("arst_rdy",   rdy_rr, 4'b0000);
        clk_edge();
        rst_n = 1'b1;
        settle();
        check("arst_first_rdy", rdy_rr, 4'b0001);
        clk_edge();
        check("arst_first_ch", oc_rr, 2'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = N'($urandom);
            sel       = IW'($urandom);
            out_ready = ($urandom % 4) != 0;
            rand_data();
            settle();
            clk_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
